// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - size codes, FSM states and legality helper for the load/store unit
package load_store_unit_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  // A request may go to the bus only if its size code exists, it is naturally
  // aligned, and it is not an unsigned-size store (BU/HU have no store form).
  function automatic logic lsu_legal(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic ok;
    case (funct3)
      FUNCT3_B:  ok = 1'b1;
      FUNCT3_BU: ok = !we;
      FUNCT3_H:  ok = !off[0];
      FUNCT3_HU: ok = !we && !off[0];
      FUNCT3_W:  ok = (off == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane enables, store replication and load extraction/extension
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic            i_we,
  input  logic [2:0]      i_st_funct3,
  input  logic [1:0]      i_st_off,
  input  logic [31:0]     i_st_data,
  output logic [BE_W-1:0] o_be,
  output logic [31:0]     o_wdata,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_off,
  input  logic [31:0]     i_ld_word,
  output logic [31:0]     o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Stores replicate the datum across all lanes so the enables alone pick the target bytes
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    if (i_we) begin
      case (i_st_funct3)
        FUNCT3_B: begin
          o_be    = 4'b0001 << i_st_off;
          o_wdata = {4{i_st_data[7:0]}};
        end
        FUNCT3_H: begin
          o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_st_data[15:0]}};
        end
        default: begin
          o_be    = 4'b1111;
          o_wdata = i_st_data;
        end
      endcase
    end
  end

  // Loads pick the addressed byte/half out of the returned word and extend it
  always_comb begin
    w_byte    = i_ld_word[{i_ld_off, 3'b000} +: 8];
    w_half    = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    o_ld_data = i_ld_word;
    case (i_ld_funct3)
      FUNCT3_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
      FUNCT3_BU: o_ld_data = {24'd0, w_byte};
      FUNCT3_H:  o_ld_data = {{16{w_half[15]}}, w_half};
      FUNCT3_HU: o_ld_data = {16'd0, w_half};
      default:   o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit driving a multi-cycle data bus
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_LEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_LEN-1:0]  req_wdata,
  output logic                 stall,
  output logic [WORD_LEN-1:0]  rdata,
  output logic                 misalign,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output logic                 bus_we,
  output logic [ADDR_SIZE-1:0] bus_addr,
  output logic [BE_W-1:0]      bus_be,
  output logic [WORD_LEN-1:0]  bus_wdata,
  input  logic                 bus_rsp_valid,
  input  logic [WORD_LEN-1:0]  bus_rdata
);

  lsu_state_t           r_state;
  logic                 r_bus_req_valid;
  logic                 r_bus_we;
  logic [ADDR_SIZE-1:0] r_bus_addr;
  logic [BE_W-1:0]      r_bus_be;
  logic [WORD_LEN-1:0]  r_bus_wdata;
  logic [2:0]           r_funct3;
  logic [1:0]           r_off;
  logic [WORD_LEN-1:0]  r_rdata;
  logic                 r_misalign;

  logic [BE_W-1:0]      w_be;
  logic [WORD_LEN-1:0]  w_wdata;
  logic [WORD_LEN-1:0]  w_ld_data;
  logic                 w_legal;

  lsu_lane_align u_lane_align (
    .i_we        (req_we),
    .i_st_funct3 (req_funct3),
    .i_st_off    (req_addr[1:0]),
    .i_st_data   (req_wdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_ld_word   (bus_rdata),
    .o_ld_data   (w_ld_data)
  );

  assign w_legal = lsu_legal(req_we, req_funct3, req_addr[1:0]);

  // Access sequencer: latch request, hand it to the bus, wait for data, report for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= LSU_IDLE;
      r_bus_req_valid <= 1'b0;
      r_bus_we        <= 1'b0;
      r_bus_addr      <= '0;
      r_bus_be        <= '0;
      r_bus_wdata     <= '0;
      r_funct3        <= 3'b000;
      r_off           <= 2'b00;
      r_rdata         <= '0;
      r_misalign      <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            if (w_legal) begin
              r_bus_addr      <= {req_addr[ADDR_SIZE-1:2], 2'b00};
              r_bus_be        <= w_be;
              r_bus_wdata     <= w_wdata;
              r_bus_we        <= req_we;
              r_funct3        <= req_funct3;
              r_off           <= req_addr[1:0];
              r_bus_req_valid <= 1'b1;
              r_state         <= LSU_REQ;
            end else begin
              r_misalign <= 1'b1;
              r_state    <= LSU_DONE;
            end
          end
        end
        LSU_REQ: begin
          if (bus_req_ready) begin
            r_bus_req_valid <= 1'b0;
            r_state         <= r_bus_we ? LSU_DONE : LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (bus_rsp_valid) begin
            r_rdata <= w_ld_data;
            r_state <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          r_misalign <= 1'b0;
          r_state    <= LSU_IDLE;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign stall         = req_valid && (r_state != LSU_DONE);
  assign rdata         = r_rdata;
  assign misalign      = r_misalign;
  assign bus_req_valid = r_bus_req_valid;
  assign bus_we        = r_bus_we;
  assign bus_addr      = r_bus_addr;
  assign bus_be        = r_bus_be;
  assign bus_wdata     = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a byte-memory reference
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, misalign;
  logic [31:0] rdata;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_rsp_valid;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_SIZE(32), .WORD_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .misalign(misalign),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  logic [7:0]  mem [0:4095];
  logic [31:0] model_rdata;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] f3, input int addr);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return ((addr % sz(f3)) == 0) && !(we && f3[2]);
  endfunction

  function automatic logic [31:0] mem_word(input int addr);
    int b;
    b = addr & 32'hFFC;
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int addr);
    int n;
    logic [31:0] v;
    n = sz(f3);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mem[addr+k]) << (8*k));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic set_word(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[addr+k] = w[8*k +: 8];
  endtask

  // One complete access; leaves req_valid high with the DUT sampled in DONE.
  task automatic run_op(input logic we, input logic [2:0] f3, input int addr,
                        input logic [31:0] wd, input int rlat, input int slat);
    int n, stalls, rw, sw, exp_stalls;
    logic legal, acc, rsp, seen, done;
    logic [31:0] a0, d0, exp_wd;
    logic [3:0]  b0, exp_be;
    n     = sz(f3);
    legal = is_legal(we, f3, addr);
    exp_be = we ? 4'(((1 << n) - 1) << (addr & 3)) : 4'b1111;
    exp_wd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    stalls = 0; rw = 0; sw = 0; acc = 0; rsp = 0; seen = 0; done = 0;
    a0 = 0; d0 = 0; b0 = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!stall) begin done = 1; break; end
      stalls++;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      if (bus_req_valid) begin
        if (!seen) begin
          chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
          chk("bus_we", 32'(bus_we), 32'(we));
          chk("bus_be", 32'(bus_be), 32'(exp_be));
          if (we) chk("bus_wdata", bus_wdata, exp_wd);
          a0 = bus_addr; b0 = bus_be; d0 = bus_wdata; seen = 1;
        end else begin
          chk("hold_addr", bus_addr, a0);
          chk("hold_be", 32'(bus_be), 32'(b0));
          chk("hold_wdata", bus_wdata, d0);
          chk("hold_we", 32'(bus_we), 32'(we));
        end
        if (rw >= rlat) begin
          bus_req_ready = 1'b1;
          acc = 1;
          if (we) for (int k = 0; k < n; k++) mem[addr+k] = wd[8*k +: 8];
        end
        rw++;
      end else if (acc && !we && !rsp) begin
        if (sw >= slat) begin
          bus_rsp_valid = 1'b1;
          bus_rdata = mem_word(addr);
          rsp = 1;
        end else begin
          bus_rdata = $urandom;
        end
        sw++;
      end
      @(negedge clk);
    end
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    if (legal && !we) model_rdata = ref_load(f3, addr);
    exp_stalls = !legal ? 1 : (we ? 2 + rlat : 3 + rlat + slat);
    chk("done_reached", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("bus_used", 32'(seen), 32'(legal));
    chk("misalign", 32'(misalign), 32'(!legal));
    chk("rdata", rdata, model_rdata);
    chk("req_valid_done", 32'(bus_req_valid), 32'd0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_misalign", 32'(misalign), 32'd0);
    chk("idle_busvalid", 32'(bus_req_valid), 32'd0);
    chk("idle_rdata", rdata, model_rdata);
  endtask

  initial begin
    logic [2:0] f3;
    int addr;
    logic we;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    model_rdata = 32'd0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'd0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_busvalid", 32'(bus_req_valid), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // SB to the top lane
    run_op(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 0, 0);
    chk("sb_mem", 32'(mem[32'h103]), 32'hA5);
    idle_check();
    // LB / LBU sign handling
    set_word(32'h100, 32'h1234_80FF);
    run_op(1'b0, 3'b000, 32'h101, 32'h0, 0, 0);
    chk("lb_const", rdata, 32'hFFFF_FF80);
    run_op(1'b0, 3'b100, 32'h101, 32'h0, 0, 0);
    chk("lbu_const", rdata, 32'h0000_0080);
    set_word(32'h100, 32'hBEEF_0000);
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 0);
    chk("lhu_const", rdata, 32'h0000_BEEF);
    idle_check();
    // Misaligned word load, illegal size code, unsigned-size store
    run_op(1'b0, 3'b010, 32'h202, 32'h0, 0, 0);
    run_op(1'b0, 3'b011, 32'h200, 32'h0, 0, 0);
    run_op(1'b1, 3'b101, 32'h200, 32'h1234, 0, 0);
    idle_check();
    // SW with the bus stalling for 5 cycles
    run_op(1'b1, 3'b010, 32'h180, 32'hCAFE_F00D, 5, 0);
    // Back-to-back store then load of the same word
    run_op(1'b1, 3'b010, 32'h300, 32'h5A6B_7C8D, 0, 0);
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 0, 0);
    chk("b2b_word", rdata, 32'h5A6B_7C8D);
    idle_check();

    // Reset while waiting for load data
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    #1;
    chk("rstw_req", 32'(bus_req_valid), 32'd1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    #1;
    chk("rstw_wait", 32'(bus_req_valid), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    model_rdata = 32'd0;
    chk("rstw_rdata", rdata, 32'd0);
    chk("rstw_addr", bus_addr, 32'd0);
    chk("rstw_be", 32'(bus_be), 32'd0);
    chk("rstw_wdata", bus_wdata, 32'd0);
    chk("rstw_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    #1;
    chk("rstw_late_rsp", rdata, 32'd0);
    chk("rstw_idle", 32'(bus_req_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      f3   = 3'($urandom_range(0, 7));
      we   = 1'($urandom);
      addr = $urandom_range(0, 4092);
      if ($urandom_range(0, 3) != 0 && sz(f3) != 0) addr = addr & ~(sz(f3) - 1);
      run_op(we, f3, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle_check();
    end
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits in the MEM stage between the pipeline and a multi-cycle data-memory bus, replacing the single-cycle data memory path.
- Converts load/store requests (address, funct3 size code, store data) into word-aligned bus transactions with byte enables.
- Sign- or zero-extends load data back to the pipeline.
- Asserts a stall until the access completes, so upstream pipeline registers hold.

Parameters:
ADDR_SIZE, 32, width of the byte address from the pipeline and of the bus address.
WORD_LEN, 32, data word width (fixed at 32; byte-lane logic assumes 4 lanes).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  MEM stage holds a load or store this cycle.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  ADDR_SIZE  byte address (ALU result).
req_wdata  in  WORD_LEN  store data (rs2 after forwarding).
stall  out  1  hold pipeline; low only when access finished or no request.
rdata  out  WORD_LEN  extended load result, valid in DONE.
misalign  out  1  access fault pulse, valid in DONE.
bus_req_valid  out  1  bus request valid.
bus_req_ready  in  1  bus accepts request.
bus_we  out  1  bus write.
bus_addr  out  ADDR_SIZE  word-aligned address, low 2 bits 0.
bus_be  out  4  byte enables.
bus_wdata  out  WORD_LEN  lane-replicated store data.
bus_rsp_valid  in  1  read data returned.
bus_rdata  in  WORD_LEN  read word.

Behaviour:
- Reset (rst low, async): state IDLE. stall, rdata, misalign, bus_req_valid, bus_we, bus_addr, bus_be and bus_wdata all 0. Any bus transaction in flight is abandoned; a later bus_rsp_valid is ignored while in IDLE.
- stall = req_valid && state != DONE (combinational).

FSM states IDLE, REQ, WAIT, DONE:
- IDLE, req_valid=0: remain in IDLE.
- IDLE, req_valid=1 and legal: register bus_addr, bus_be, bus_wdata, bus_we, funct3 and addr[1:0]; go to REQ.
- IDLE, req_valid=1 and illegal: go to DONE with misalign=1 and no bus activity.
  - Illegal means: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; or a store with funct3 100/101.
- REQ: bus_req_valid=1, all bus fields held stable until bus_req_ready.
  - On ready with a store: go to DONE.
  - On ready with a load: go to WAIT.
- WAIT: bus_req_valid=0. On bus_rsp_valid, capture the extended bus_rdata into rdata and go to DONE.
- DONE: stall=0 for exactly one cycle; rdata and misalign are held. Always return to IDLE next cycle. A back-to-back memory op therefore enters IDLE and is issued from there.
- misalign clears on leaving DONE. rdata holds its value until the next load completes.

Byte lanes (o = addr[1:0]):
- SB: be = 1<<o; wdata = {4{byte}}.
- SH: be = o[1] ? 1100 : 0011; wdata = {2{half}}.
- SW: be = 1111.
- Loads: bus_be = 1111. Select byte o or half o[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.

Latency:
- Store with ready high: 2 stall cycles.
- Load with ready high and response one cycle after accept: 3 stall cycles.
- Misaligned access: 1 stall cycle.

Simultaneous events and corner cases:
- bus_rsp_valid in the same cycle as acceptance is not legal for the bus; the unit samples responses only in WAIT.
- req_valid dropping mid-access is not expected; the FSM completes the access regardless.

Decomposition:
- defines.v gains:
  - funct3 size codes (FUNCT3_B/H/W/BU/HU);
  - LSU state encodings LSU_IDLE/REQ/WAIT/DONE (2 bits);
  - BE width constant 4.
- One combinational sub-module, lsu_lane_align, holds the be/wdata generation and load extraction/extension so it can be unit-tested alone. The FSM stays in load_store_unit.

Test Plan:
- SB addr=0x103, wdata=0x000000A5, ready high -> bus_addr=0x100, be=1000, bus_wdata=0xA5A5A5A5, bus_we=1; stall high 2 cycles, then low 1 cycle in DONE.
- LB addr=0x101, bus_rdata=0x1234_80FF, response 1 cycle after accept -> rdata=0xFFFF_FF80.
- Same as above with LBU -> rdata=0x0000_0080.
- LHU addr=0x102, bus_rdata=0xBEEF_0000 -> rdata=0x0000_BEEF; be=1111.
- LW addr=0x202 -> no bus_req_valid; DONE next cycle with misalign=1; stall high 1 cycle.
- SW with ready held low 5 cycles -> bus fields stable throughout, stall stays high.
- Load in WAIT, rst pulsed low -> all outputs 0 immediately; a later bus_rsp_valid does not change rdata.
- Back-to-back SW 0x300 then LW 0x300 (bus model returns written data) -> rdata equals the stored word.
